eight_bit_serial_subtractor: RTL

Bit-serial subtractor computing A − B − Bin over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart of the combinational eight-bit ripple adder. It sits behind a start/done handshake so a sequential controller or testbench can issue one operation at a time and read a stable, registered result.

---
 rtl/eight_bit_serial_subtractor_pkg.sv | 25 ++
 rtl/eight_bit_serial_subtractor_if.sv | 27 ++
 rtl/eight_bit_serial_subtractor_full_subtractor.sv | 13 +
 rtl/eight_bit_serial_subtractor.sv | 133 +++++++++++++
 4 files changed

// File: rtl/eight_bit_serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/eight_bit_serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the serial subtractor.
// Ovf is present only when SERIAL_SUB_OVF_EN is defined.
interface eight_bit_serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             Ovf;

  modport master (output start, A, B, Bin, input busy, done, Diff, Borrow, Ovf);
  modport slave  (input start, A, B, Bin, output busy, done, Diff, Borrow, Ovf);
`else
  modport master (output start, A, B, Bin, input busy, done, Diff, Borrow);
  modport slave  (input start, A, B, Bin, output busy, done, Diff, Borrow);
`endif

endinterface

// File: rtl/eight_bit_serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell and a borrow flop.
// Optional signed overflow output with SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one result bit per edge, WIDTH edges total
// DONE  | one-cycle done pulse, registered result valid
module eight_bit_serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  eight_bit_serial_subtractor_if.slave bus
);

  localparam int CW = clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             shift;
  logic             busy;
  logic             done;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] diff_q;
  logic             brw;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bout;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: load = bus.start;
      RUN: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (d),
    .bout (bout)
  );

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      a_msb <= bus.A[WIDTH-1];
      b_msb <= bus.B[WIDTH-1];
    end else if (shift && last) begin
      // d here is the MSB of the completed difference
      ovf_q <= (a_msb ^ b_msb) & (a_msb ^ d);
    end
  end

  assign bus.Ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      diff_q   <= '0;
      brw      <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      a_sh <= bus.A;
      b_sh <= bus.B;
      brw  <= bus.Bin;
      cnt  <= '0;
    end else if (shift) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= {d, d_sh[WIDTH-1:1]};
      brw  <= bout;
      cnt  <= cnt + 1'b1;
      // result registers see the final bit directly, never a partial value
      if (last) begin
        diff_q   <= {d, d_sh[WIDTH-1:1]};
        borrow_q <= bout;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.Diff   = diff_q;
  assign bus.Borrow = borrow_q;

endmodule
